// File: rtl/data_mem_resp_if.sv
// MEM-stage <-> data memory request/response bundle.
// master = pipeline side, slave = memory responder.
interface data_mem_resp_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        misalign;

  modport master (
    output mem_read, mem_write, mem_type, mem_addr, write_data,
    input  read_data, mem_stall, misalign
  );

  modport slave (
    input  mem_read, mem_write, mem_type, mem_addr, write_data,
    output read_data, mem_stall, misalign
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data memory responder: byte-lane stores, sign/zero-extended loads.
// Latency LATENCY+1 stall cycles per access; request held by the pipeline while mem_stall=1.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   widx_q;
  logic [1:0]      lane_q;
  logic [31:0]     wdata_q;
  logic [2:0]      type_q;
  logic            is_write_q;
  logic [31:0]     rdata_q;
  logic [31:0]     rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req, type_ok, aligned, accept;
  logic [31:0]     word, half_w, byte_w;
  logic [3:0]      be;
  logic [31:0]     wrep;
  logic            unused_addr;

  assign unused_addr = ^bus.mem_addr[31:AW+2];

  always_comb begin
    req     = bus.mem_read | bus.mem_write;
    type_ok = 1'b0;
    aligned = 1'b1;
    case (bus.mem_type)
      3'b000, 3'b100:         type_ok = 1'b1;
      3'b001, 3'b101: begin   type_ok = 1'b1; aligned = ~bus.mem_addr[0];           end
      3'b010:         begin   type_ok = 1'b1; aligned = (bus.mem_addr[1:0] == 2'b00); end
      default:                type_ok = 1'b0;
    endcase
    accept = (state_q == IDLE) & req & type_ok & aligned;
  end

  // Stall rises combinationally on acceptance so the pipeline freezes in the same cycle.
  assign bus.mem_stall = (state_q == BUSY) | accept;
  assign bus.misalign  = (state_q == IDLE) & req & type_ok & ~aligned;
  assign bus.read_data = rdata_q;

  always_comb begin
    word   = mem_q[widx_q];
    byte_w = word >> {lane_q, 3'b000};
    half_w = word >> {lane_q[1], 4'b0000};
    rdata_d = 32'h0;
    if (!is_write_q) begin
      case (type_q)
        3'b000:  rdata_d = {{24{byte_w[7]}}, byte_w[7:0]};
        3'b001:  rdata_d = {{16{half_w[15]}}, half_w[15:0]};
        3'b010:  rdata_d = word;
        3'b100:  rdata_d = {24'h0, byte_w[7:0]};
        3'b101:  rdata_d = {16'h0, half_w[15:0]};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // Store size comes from funct3[1:0]; data is replicated so each lane sees its slice.
  always_comb begin
    be   = 4'b0000;
    wrep = wdata_q;
    case (type_q[1:0])
      2'b00:   begin be = 4'b0001 << lane_q;                  wrep = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = lane_q[1] ? 4'b1100 : 4'b0011;      wrep = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;                            wrep = wdata_q;            end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == BUSY && cnt_q == '0 && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx_q][i*8 +: 8] <= wrep[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            widx_q     <= bus.mem_addr[AW+1:2];
            lane_q     <= bus.mem_addr[1:0];
            wdata_q    <= bus.write_data;
            type_q     <= bus.mem_type;
            is_write_q <= bus.mem_write;
            cnt_q      <= CW'(LATENCY - 1);
            state_q    <= BUSY;
          end else if (req) begin
            rdata_q <= 32'h0;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rdata_q <= rdata_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed + randomized check of data_mem_resp against a byte-array reference model.
module tb_data_mem_resp;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  logic [31:0] mdl [1024];
  logic [2:0]  types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  data_mem_resp_if bif ();
  data_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mdl_load(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mdl[a[11:2]];
    b = w[int'(a[1:0])*8 +: 8];
    h = w[int'(a[1])*16 +: 16];
    case (t)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b010:  return w;
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void mdl_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    case (t[1:0])
      2'b00:   mdl[a[11:2]][int'(a[1:0])*8 +: 8]  = d[7:0];
      2'b01:   mdl[a[11:2]][int'(a[1])*16 +: 16]  = d[15:0];
      default: mdl[a[11:2]] = d;
    endcase
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    bif.mem_read = rd; bif.mem_write = wr; bif.mem_type = t;
    bif.mem_addr = a;  bif.write_data = d;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] exp;
    int n;
    exp = wr ? 32'h0 : mdl_load(t, a);
    @(posedge clk); #1;
    drive(rd, wr, t, a, d);
    n = 0;
    @(negedge clk);
    while (bif.mem_stall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall_cycles"}, n, LAT + 1);
    check({tag, " read_data"}, bif.read_data, exp);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    if (wr) mdl_store(t, a, d);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [2:0] t,
                     input logic [31:0] a, input logic exp_mis, input string tag);
    @(posedge clk); #1;
    drive(rd, wr, t, a, 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, " misalign"}, 32'(bif.misalign), 32'(exp_mis));
    check({tag, " stall"}, 32'(bif.mem_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, " misalign_clear"}, 32'(bif.misalign), 32'h0);
    check({tag, " read_data_zero"}, bif.read_data, 32'h0);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a, d;
    int op;
    logic mis;

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset read_data", bif.read_data, 32'h0);
    check("reset stall", 32'(bif.mem_stall), 32'h0);
    check("reset misalign", 32'(bif.misalign), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 3'b010, 32'(i * 4), 32'h0, "init");

    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "SW 0x10");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "LW 0x10");
    check("LW 0x10 const", bif.read_data, 32'hDEADBEEF);

    access(1'b0, 1'b1, 3'b000, 32'h11, 32'h55, "SB 0x11");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "LW 0x10 after SB");
    check("LW after SB const", bif.read_data, 32'hDEAD55EF);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "LB 0x13");
    check("LB 0x13 const", bif.read_data, 32'hFFFFFFDE);
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "LBU 0x13");
    check("LBU 0x13 const", bif.read_data, 32'h000000DE);

    access(1'b0, 1'b1, 3'b001, 32'h22, 32'h8001, "SH 0x22");
    access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, "LH 0x22");
    check("LH 0x22 const", bif.read_data, 32'hFFFF8001);
    access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, "LHU 0x22");
    check("LHU 0x22 const", bif.read_data, 32'h00008001);
    access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, "LHU 0x20 low half");

    bad(1'b1, 1'b0, 3'b010, 32'h13, 1'b1, "LW 0x13");
    bad(1'b0, 1'b1, 3'b001, 32'h21, 1'b1, "SH 0x21");
    bad(1'b1, 1'b0, 3'b011, 32'h10, 1'b0, "invalid type 011");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "LW 0x10 after misalign");
    check("LW 0x10 unchanged", bif.read_data, 32'hDEAD55EF);

    // Reset during the first BUSY cycle abandons the store.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b010, 32'h30, 32'h12345678);
    @(negedge clk);
    check("SW 0x30 stall before rst", 32'(bif.mem_stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after rst stall", 32'(bif.mem_stall), 32'h0);
    check("after rst misalign", 32'(bif.misalign), 32'h0);
    check("after rst read_data", bif.read_data, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, "LW 0x30 after rst");
    check("LW 0x30 prior value", bif.read_data, 32'h0);

    access(1'b0, 1'b1, 3'b010, 32'h1004, 32'hA5A5A5A5, "SW 0x1004");
    access(1'b1, 1'b0, 3'b010, 32'h0004, 32'h0, "LW 0x0004 wrap");
    check("wrap const", bif.read_data, 32'hA5A5A5A5);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 2);
      t  = (op == 0) ? types[$urandom_range(0, 4)] : types[$urandom_range(0, 2)];
      a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      d  = $urandom();
      mis = ((t[1:0] == 2'b01) && a[0]) || ((t == 3'b010) && (a[1:0] != 2'b00));
      if (mis) bad(op != 1, op != 0, t, a, 1'b1, "rand misaligned");
      else     access(op != 1, op != 0, t, a, d, "rand access");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
